// File: rtl/sys_proto_pkg.sv
// sys_proto_pkg: opcode bytes, op encodings, frame lengths and states shared
// by the command master and the system controller.
package sys_proto_pkg;

  localparam logic [7:0] REG_WRITE = 8'hAA;
  localparam logic [7:0] REG_READ  = 8'hBB;
  localparam logic [7:0] ALU_W_OP  = 8'hCC;
  localparam logic [7:0] ALU_N_OP  = 8'hDD;

  typedef enum logic [1:0] {
    OP_WR    = 2'b00,
    OP_RD    = 2'b01,
    OP_ALU_W = 2'b10,
    OP_ALU_N = 2'b11
  } cmd_op_e;

  localparam logic [2:0] LEN_WR    = 3'd3;
  localparam logic [2:0] LEN_RD    = 3'd2;
  localparam logic [2:0] LEN_ALU_W = 3'd4;
  localparam logic [2:0] LEN_ALU_N = 3'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_RSP0 = 2'd2,
    WAIT_RSP1 = 2'd3
  } state_e;

  function automatic logic [7:0] op_byte(input cmd_op_e op);
    logic [7:0] b;
    unique case (op)
      OP_WR:    b = REG_WRITE;
      OP_RD:    b = REG_READ;
      OP_ALU_W: b = ALU_W_OP;
      OP_ALU_N: b = ALU_N_OP;
    endcase
    return b;
  endfunction

  function automatic logic [2:0] frame_len(input cmd_op_e op);
    logic [2:0] n;
    unique case (op)
      OP_WR:    n = LEN_WR;
      OP_RD:    n = LEN_RD;
      OP_ALU_W: n = LEN_ALU_W;
      OP_ALU_N: n = LEN_ALU_N;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sys_rsp_timer.sv
// sys_rsp_timer: response gap counter; expires once it has
// counted TIMEOUT_CYC-1 enabled cycles since the last clear.
module sys_rsp_timer #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] r_cnt;

  assign o_expire = (r_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_en && !o_expire)
      r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/sys_cmd_master.sv
// sys_cmd_master: serialises one command into a protocol frame and collects
// the reply. Response timeout is built only with SYS_CMD_MASTER_TIMEOUT_EN.
module sys_cmd_master
  import sys_proto_pkg::*;
#(
  parameter int BUS_WIDTH   = 8,
  parameter int Reg_Addr    = 4,
  parameter int ALU_FUN     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   REF_CLK,
  input  logic                   SYNC_RST,
  input  logic                   CMD_VALID,
  output logic                   CMD_READY,
  input  logic [1:0]             CMD_OP,
  input  logic [Reg_Addr-1:0]    CMD_ADDR,
  input  logic [BUS_WIDTH-1:0]   CMD_WDATA,
  input  logic [BUS_WIDTH-1:0]   CMD_OP_A,
  input  logic [BUS_WIDTH-1:0]   CMD_OP_B,
  input  logic [ALU_FUN-1:0]     CMD_FUN,
  output logic [BUS_WIDTH-1:0]   TX_DATA,
  output logic                   TX_VALID,
  input  logic                   TX_READY,
  input  logic [BUS_WIDTH-1:0]   RX_DATA,
  input  logic                   RX_VALID,
  output logic [2*BUS_WIDTH-1:0] RSP_DATA,
  output logic                   RSP_VALID,
  output logic                   RSP_TIMEOUT,
  output logic                   BUSY
);

  state_e                 r_state, w_next;
  cmd_op_e                r_op;
  logic [Reg_Addr-1:0]    r_addr;
  logic [BUS_WIDTH-1:0]   r_wdata, r_op_a, r_op_b;
  logic [ALU_FUN-1:0]     r_fun;
  logic [2:0]             r_idx, r_len, w_nidx;
  logic [BUS_WIDTH-1:0]   r_tx_data, w_nbyte;
  logic [BUS_WIDTH-1:0]   w_addr_b, w_fun_b;
  logic                   r_tx_valid;
  logic [2*BUS_WIDTH-1:0] r_rsp_data;
  logic                   r_rsp_valid;
  logic                   w_accept, w_tx_hs;
  logic                   w_last, w_timeout;

  assign w_accept = CMD_VALID & (r_state == IDLE);
  assign w_tx_hs  = r_tx_valid & TX_READY;
  assign w_last   = w_tx_hs & (r_idx == r_len - 3'd1);
  assign w_nidx   = r_idx + 3'd1;
  assign w_addr_b = BUS_WIDTH'(r_addr);
  assign w_fun_b  = BUS_WIDTH'(r_fun);

`ifdef SYS_CMD_MASTER_TIMEOUT_EN
  logic w_wait, w_expire, r_rsp_to;

  assign w_wait = (r_state == WAIT_RSP0) |
                  (r_state == WAIT_RSP1);

  sys_rsp_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rsp_timer (
    .i_clk    (REF_CLK),
    .i_rst_n  (SYNC_RST),
    .i_clr    (~w_wait | RX_VALID),
    .i_en     (w_wait),
    .o_expire (w_expire)
  );

  // A byte arriving on the expiry cycle beats the timeout
  assign w_timeout = w_wait & w_expire & ~RX_VALID;

  always_ff @(posedge REF_CLK or negedge SYNC_RST) begin
    if (!SYNC_RST) r_rsp_to <= 1'b0;
    else           r_rsp_to <= w_timeout;
  end

  assign RSP_TIMEOUT = r_rsp_to;
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYC != 0);
  assign w_timeout   = 1'b0;
  assign RSP_TIMEOUT = 1'b0;
`endif

  always_ff @(posedge REF_CLK or negedge SYNC_RST) begin
    if (!SYNC_RST) r_state <= IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (w_accept) w_next = SEND;
      SEND:
        if (w_last)
          w_next = (r_op == OP_WR) ? IDLE : WAIT_RSP0;
      WAIT_RSP0:
        if (RX_VALID)
          w_next = (r_op == OP_RD) ? IDLE : WAIT_RSP1;
        else if (w_timeout)
          w_next = IDLE;
      WAIT_RSP1:
        if (RX_VALID || w_timeout) w_next = IDLE;
    endcase
  end

  // Byte that follows the one currently on TX_DATA
  always_comb begin
    w_nbyte = '0;
    unique case (1'b1)
      (r_op == OP_WR):
        w_nbyte = (w_nidx == 3'd1) ? w_addr_b : r_wdata;
      (r_op == OP_RD):
        w_nbyte = w_addr_b;
      (r_op == OP_ALU_W):
        w_nbyte = (w_nidx == 3'd1) ? r_op_a :
                  (w_nidx == 3'd2) ? r_op_b : w_fun_b;
      default:
        w_nbyte = w_fun_b;
    endcase
  end

  always_ff @(posedge REF_CLK or negedge SYNC_RST) begin
    if (!SYNC_RST) begin
      r_op        <= OP_WR;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_fun       <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_op       <= cmd_op_e'(CMD_OP);
        r_addr     <= CMD_ADDR;
        r_wdata    <= CMD_WDATA;
        r_op_a     <= CMD_OP_A;
        r_op_b     <= CMD_OP_B;
        r_fun      <= CMD_FUN;
        r_idx      <= '0;
        r_len      <= frame_len(cmd_op_e'(CMD_OP));
        r_tx_data  <= BUS_WIDTH'(op_byte(cmd_op_e'(CMD_OP)));
        r_tx_valid <= 1'b1;
      end
      if (w_tx_hs) begin
        if (w_last) begin
          r_tx_valid <= 1'b0;
          if (r_op == OP_WR) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
          end
        end else begin
          r_idx     <= w_nidx;
          r_tx_data <= w_nbyte;
        end
      end
      if (r_state == WAIT_RSP0 && RX_VALID) begin
        r_rsp_data[BUS_WIDTH-1:0] <= RX_DATA;
        if (r_op == OP_RD) begin
          r_rsp_data[2*BUS_WIDTH-1:BUS_WIDTH] <= '0;
          r_rsp_valid <= 1'b1;
        end
      end
      if (r_state == WAIT_RSP1 && RX_VALID) begin
        r_rsp_data[2*BUS_WIDTH-1:BUS_WIDTH] <= RX_DATA;
        r_rsp_valid <= 1'b1;
      end
    end
  end

  assign CMD_READY = (r_state == IDLE);
  assign BUSY      = (r_state != IDLE);
  assign TX_DATA   = r_tx_data;
  assign TX_VALID  = r_tx_valid;
  assign RSP_DATA  = r_rsp_data;
  assign RSP_VALID = r_rsp_valid;

endmodule

// File: tb/tb_sys_cmd_master.sv
// tb_sys_cmd_master: scoreboard bench with a frame/response reference model
// and a negedge monitor for TX bytes and responses.
module tb_sys_cmd_master;

  localparam int TO = 64;

  logic        REF_CLK = 1'b0;
  logic        SYNC_RST = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [1:0]  CMD_OP = '0;
  logic [3:0]  CMD_ADDR = '0;
  logic [7:0]  CMD_WDATA = '0;
  logic [7:0]  CMD_OP_A = '0;
  logic [7:0]  CMD_OP_B = '0;
  logic [3:0]  CMD_FUN = '0;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY = 1'b1;
  logic [7:0]  RX_DATA = '0;
  logic        RX_VALID = 1'b0;
  logic [15:0] RSP_DATA;
  logic        RSP_VALID;
  logic        RSP_TIMEOUT;
  logic        BUSY;

  sys_cmd_master #(
    .BUS_WIDTH(8), .Reg_Addr(4), .ALU_FUN(4), .TIMEOUT_CYC(TO)
  ) dut (
    .REF_CLK(REF_CLK), .SYNC_RST(SYNC_RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_ADDR(CMD_ADDR),
    .CMD_WDATA(CMD_WDATA), .CMD_OP_A(CMD_OP_A),
    .CMD_OP_B(CMD_OP_B), .CMD_FUN(CMD_FUN),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
    .TX_READY(TX_READY), .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID), .RSP_DATA(RSP_DATA),
    .RSP_VALID(RSP_VALID), .RSP_TIMEOUT(RSP_TIMEOUT),
    .BUSY(BUSY)
  );

  always #5 REF_CLK = ~REF_CLK;

  typedef struct {
    logic [15:0] data;
    bit          to;
  } rsp_t;

  logic [7:0] tx_q[$];
  rsp_t       rsp_q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         tx_mode = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Reference model: frame bytes straight from the frame layouts
  task automatic push_frame(input int op, input logic [3:0] addr,
                            input logic [7:0] wd, input logic [7:0] a,
                            input logic [7:0] b, input logic [3:0] fun);
    case (op)
      0: begin
        tx_q.push_back(8'hAA); tx_q.push_back({4'h0, addr});
        tx_q.push_back(wd);
      end
      1: begin
        tx_q.push_back(8'hBB); tx_q.push_back({4'h0, addr});
      end
      2: begin
        tx_q.push_back(8'hCC); tx_q.push_back(a);
        tx_q.push_back(b); tx_q.push_back({4'h0, fun});
      end
      default: begin
        tx_q.push_back(8'hDD); tx_q.push_back({4'h0, fun});
      end
    endcase
  endtask

  task automatic push_rsp(input logic [15:0] d, input bit to);
    rsp_t r;
    r.data = d;
    r.to = to;
    rsp_q.push_back(r);
  endtask

  function automatic logic [15:0] model_rsp(input int op,
      input logic [7:0] r0, input logic [7:0] r1);
    if (op == 0) return 16'h0000;
    if (op == 1) return {8'h00, r0};
    return {r1, r0};
  endfunction

  // TX_READY pattern: 0 always ready, 1 toggling, 2 random
  initial forever begin
    @(posedge REF_CLK);
    #1;
    case (tx_mode)
      0: TX_READY = 1'b1;
      1: TX_READY = ~TX_READY;
      default: TX_READY = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor
  initial begin
    bit         prev_stall;
    logic [7:0] prev_data;
    rsp_t       e;
    prev_stall = 0;
    prev_data = '0;
    forever begin
      @(negedge REF_CLK);
      if (!SYNC_RST) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("tx_hold_valid", TX_VALID, 1);
          chk("tx_hold_data", TX_DATA, prev_data);
        end
        prev_stall = TX_VALID & ~TX_READY;
        prev_data = TX_DATA;
        if (TX_VALID && TX_READY) begin
          if (tx_q.size() == 0) fail("tx_unexpected");
          else chk("tx_byte", TX_DATA, tx_q.pop_front());
        end
        if (RSP_VALID || RSP_TIMEOUT) begin
          if (rsp_q.size() == 0) begin
            fail("rsp_unexpected");
          end else begin
            e = rsp_q.pop_front();
            chk("rsp_timeout_flag", RSP_TIMEOUT, e.to);
            chk("rsp_valid_flag", RSP_VALID, !e.to);
            if (e.to) chk("rsp_partial", RSP_DATA[7:0], e.data[7:0]);
            else chk("rsp_data", RSP_DATA, e.data);
            chk("rsp_cmd_ready", CMD_READY, 1);
          end
        end
      end
    end
  end

  task automatic set_cmd(input int op, input logic [3:0] addr,
                         input logic [7:0] wd, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] fun);
    CMD_OP = 2'(op);
    CMD_ADDR = addr;
    CMD_WDATA = wd;
    CMD_OP_A = a;
    CMD_OP_B = b;
    CMD_FUN = fun;
  endtask

  task automatic issue(input int op, input logic [3:0] addr,
                       input logic [7:0] wd, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] fun);
    bit ok;
    ok = 0;
    set_cmd(op, addr, wd, a, b, fun);
    CMD_VALID = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge REF_CLK);
      #1;
      if (CMD_READY) begin
        ok = 1;
        break;
      end
    end
    @(posedge REF_CLK);
    #1;
    CMD_VALID = 1'b0;
    if (!ok) fail("cmd_accept_timeout");
  endtask

  task automatic wait_tx_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge REF_CLK);
      #1;
      if (tx_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    @(posedge REF_CLK);
    #1;
    if (!ok) fail("tx_frame_timeout");
  endtask

  task automatic wait_rsp_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge REF_CLK);
      #1;
      if (rsp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    @(posedge REF_CLK);
    #1;
    if (!ok) fail("rsp_wait_timeout");
  endtask

  task automatic send_rx(input logic [7:0] b);
    RX_DATA = b;
    RX_VALID = 1'b1;
    @(posedge REF_CLK);
    #1;
    RX_VALID = 1'b0;
  endtask

  task automatic run_cmd(input int op, input logic [3:0] addr,
                         input logic [7:0] wd, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] fun,
                         input logic [7:0] r0, input logic [7:0] r1,
                         input int dly, input int gap);
    push_frame(op, addr, wd, a, b, fun);
    push_rsp(model_rsp(op, r0, r1), 0);
    issue(op, addr, wd, a, b, fun);
    wait_tx_done();
    if (op != 0) begin
      repeat (dly) @(posedge REF_CLK);
      #1;
      send_rx(r0);
      if (op >= 2) begin
        repeat (gap) @(posedge REF_CLK);
        #1;
        send_rx(r1);
      end
    end
    wait_rsp_done();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit seen;
    int op;

    repeat (3) @(posedge REF_CLK);
    #1;
    chk("rst_cmd_ready", CMD_READY, 1);
    chk("rst_tx_valid", TX_VALID, 0);
    chk("rst_tx_data", TX_DATA, 0);
    chk("rst_rsp_data", RSP_DATA, 0);
    chk("rst_rsp_valid", RSP_VALID, 0);
    chk("rst_rsp_timeout", RSP_TIMEOUT, 0);
    chk("rst_busy", BUSY, 0);
    SYNC_RST = 1'b1;
    @(posedge REF_CLK);
    #1;

    // Write: three back-to-back bytes then RSP_VALID
    push_frame(0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
    push_rsp(16'h0000, 0);
    issue(0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge REF_CLK);
      chk("wr_tx_valid", TX_VALID, 1);
    end
    @(negedge REF_CLK);
    chk("wr_rsp_cycle", RSP_VALID, 1);
    @(posedge REF_CLK);
    #1;

    // Read with a 20-cycle responder delay
    run_cmd(1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0,
            8'h7E, 8'h00, 20, 0);

    // ALU with operands under TX stalls
    tx_mode = 1;
    run_cmd(2, 4'h0, 8'h00, 8'h10, 8'h20, 4'h0,
            8'h30, 8'h00, 3, 2);
    tx_mode = 0;
    @(posedge REF_CLK);
    #1;

    // ALU without operands, only one response byte
    push_frame(3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3);
`ifdef SYS_CMD_MASTER_TIMEOUT_EN
    push_rsp(16'h0055, 1);
`else
    push_rsp(16'h1255, 0);
`endif
    issue(3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3);
    wait_tx_done();
    send_rx(8'h55);
`ifdef SYS_CMD_MASTER_TIMEOUT_EN
    k = 0;
    seen = 0;
    for (int i = 0; i < TO + 20; i++) begin
      @(posedge REF_CLK);
      #1;
      k++;
      if (RSP_TIMEOUT) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail("timeout_missing");
    else begin
      chk("timeout_latency", k, TO);
      chk("timeout_cmd_ready", CMD_READY, 1);
      chk("timeout_rsp_valid", RSP_VALID, 0);
    end
    wait_rsp_done();
`else
    repeat (TO + 10) @(posedge REF_CLK);
    #1;
    chk("no_timeout_busy", BUSY, 1);
    send_rx(8'h12);
    wait_rsp_done();
`endif

    // Reset after two bytes of a four-byte frame
    push_frame(2, 4'h0, 8'h00, 8'h11, 8'h22, 4'h5);
    issue(2, 4'h0, 8'h00, 8'h11, 8'h22, 4'h5);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge REF_CLK);
      #1;
      if (tx_q.size() <= 2) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail("rst_mid_wait");
    @(posedge REF_CLK);
    #1;
    SYNC_RST = 1'b0;
    #1;
    chk("rstmid_tx_valid", TX_VALID, 0);
    chk("rstmid_cmd_ready", CMD_READY, 1);
    chk("rstmid_busy", BUSY, 0);
    tx_q.delete();
    @(posedge REF_CLK);
    #1;
    SYNC_RST = 1'b1;
    run_cmd(1, 4'hC, 8'h00, 8'h00, 8'h00, 4'h0,
            8'h9A, 8'h00, 2, 0);

    // CMD_VALID held high, stray RX strobes while sending
    push_frame(0, 4'h9, 8'hA5, 8'h00, 8'h00, 4'h0);
    push_rsp(16'h0000, 0);
    push_frame(1, 4'hC, 8'h00, 8'h00, 8'h00, 4'h0);
    push_rsp(16'h005A, 0);
    set_cmd(0, 4'h9, 8'hA5, 8'h00, 8'h00, 4'h0);
    CMD_VALID = 1'b1;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          @(posedge REF_CLK);
          #1;
          RX_VALID = TX_VALID;
          RX_DATA = 8'($urandom);
          if (i > 3 && tx_q.size() == 0 && !TX_VALID) break;
        end
        RX_VALID = 1'b0;
      end
      begin
        @(posedge REF_CLK);
        #1;
        set_cmd(1, 4'hC, 8'h00, 8'h00, 8'h00, 4'h0);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
          @(negedge REF_CLK);
          #1;
          if (RSP_VALID) begin
            seen = 1;
            break;
          end
        end
        if (!seen) fail("b2b_rsp_missing");
        chk("b2b_ready", CMD_READY, 1);
        @(posedge REF_CLK);
        #1;
        CMD_VALID = 1'b0;
        @(negedge REF_CLK);
        chk("b2b_tx_valid", TX_VALID, 1);
        chk("b2b_opcode", TX_DATA, 8'hBB);
      end
    join
    send_rx(8'h5A);
    wait_rsp_done();

    // Randomized commands
    for (int n = 0; n < 20; n++) begin
      tx_mode = $urandom_range(0, 2);
      op = $urandom_range(0, 3);
      run_cmd(op, 4'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 4'($urandom), 8'($urandom),
              8'($urandom), $urandom_range(0, 30),
              $urandom_range(0, 10));
    end
    tx_mode = 0;
    repeat (5) @(posedge REF_CLK);

    chk("tx_q_drained", tx_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
